// File: rtl/seven_seg_scan_driver_if.sv
// Host-facing bundle of the seven-segment scan driver: display word inputs,
// load strobe, lamp test, and the multiplexed anode/segment drives.
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   en_in;
    logic                    load;
    logic                    lamp_test;

    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output digits_in, dp_in, en_in, load, lamp_test,
        input  an, seg, dp, frame_done, pending
    );

    modport slave (
        input  digits_in, dp_in, en_in, load, lamp_test,
        output an, seg, dp, frame_done, pending
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: MSD-first scan, per-slot
// anode blanking, and a double-buffered display word committed at frame ends.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 CLKDV,
    input  logic                 rst_de,
    seven_seg_scan_driver_if.slave bus
);

    localparam int IDX_W = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int CYC_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CYC_W-1:0] CYC_TOP   = CYC_W'(DWELL_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_BLANK = CYC_W'(BLANK_CYCLES);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
    } disp_t;

    localparam disp_t DISP_RST = '{digits: '0, dp: '0, en: '1};

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            4'hF: s = 7'h38;
        endcase
        return s;
    endfunction

    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    disp_t                 shadow_q, shadow_d;
    disp_t                 active_q, active_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    disp_t      load_word;
    logic       slot_end;
    logic       boundary;
    logic [3:0] cur_digit;
    logic       cur_dp;
    logic       cur_en;
    logic       lit;

    assign load_word = {bus.digits_in, bus.dp_in, bus.en_in};
    assign slot_end  = (cyc_q == CYC_TOP);
    assign boundary  = slot_end && (idx_q == '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cyc_d        = slot_end ? '0 : cyc_q + 1'b1;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        cur_digit    = '0;
        cur_dp       = 1'b0;
        cur_en       = 1'b0;
        an_d         = '1;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = boundary;

        if (slot_end) begin
            idx_d = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
        end

        if (bus.load) begin
            shadow_d = load_word;
        end

        // A load on the boundary cycle goes straight to the active word.
        if (boundary) begin
            if (bus.load) begin
                active_d = load_word;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            pending_d = 1'b1;
        end

        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_digit = active_q.digits[4*k +: 4];
                cur_dp    = active_q.dp[k];
                cur_en    = active_q.en[k];
            end
        end

        lit = (cyc_q >= CYC_BLANK) && cur_en;

        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_d[k] = !(lit && (idx_q == IDX_W'(k)));
        end

        if (lit) begin
            seg_d = bus.lamp_test ? 7'h00 : hex7(cur_digit);
            dp_d  = bus.lamp_test ? 1'b0  : ~cur_dp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: the display buffers are reset too, so a reset mid-frame discards any queued word.
    always_ff @(posedge CLKDV or posedge rst_de) begin
        if (rst_de) begin
            cyc_q        <= '0;
            idx_q        <= IDX_TOP;
            shadow_q     <= DISP_RST;
            active_q     <= DISP_RST;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cyc_q        <= cyc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: cycle scoreboard from a
// reference model plus table-driven decode vectors and frame-level sequences.
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int D     = 16;
    localparam int B     = 2;
    localparam int FRAME = N * D;
    localparam int LIT   = D - B;

    localparam logic [6:0] HEX7 [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic CLKDV  = 1'b0;
    logic rst_de = 1'b0;

    seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan_driver #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .CLKDV (CLKDV),
        .rst_de(rst_de),
        .bus   (bus)
    );

    always #5 CLKDV = ~CLKDV;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state, mirrors what the DUT holds during the current cycle.
    int          m_cyc, m_idx;
    logic [15:0] m_sh_dig, m_ac_dig;
    logic [3:0]  m_sh_dp, m_ac_dp, m_sh_en, m_ac_en;
    logic        m_pend;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       pend;
    } obs_t;

    obs_t exp_q[$];

    initial begin
        obs_t e, got;
        logic lit;
        forever begin
            @(posedge CLKDV);
            if (rst_de) begin
                m_cyc = 0; m_idx = N - 1;
                m_sh_dig = '0; m_ac_dig = '0;
                m_sh_dp  = '0; m_ac_dp  = '0;
                m_sh_en  = '1; m_ac_en  = '1;
                m_pend   = 1'b0;
                exp_q.delete();
            end else begin
                lit   = (m_cyc >= B) && m_ac_en[m_idx];
                e.an  = lit ? ~(4'b0001 << m_idx) : 4'hF;
                e.seg = !lit ? 7'h7F : (bus.lamp_test ? 7'h00 : HEX7[m_ac_dig[4*m_idx +: 4]]);
                e.dp  = !lit ? 1'b1 : (bus.lamp_test ? 1'b0 : ~m_ac_dp[m_idx]);
                e.fd  = (m_cyc == D - 1) && (m_idx == 0);
                if (e.fd) begin
                    if (bus.load) begin
                        m_ac_dig = bus.digits_in; m_ac_dp = bus.dp_in; m_ac_en = bus.en_in;
                    end else if (m_pend) begin
                        m_ac_dig = m_sh_dig; m_ac_dp = m_sh_dp; m_ac_en = m_sh_en;
                    end
                    m_pend = 1'b0;
                end else if (bus.load) begin
                    m_sh_dig = bus.digits_in; m_sh_dp = bus.dp_in; m_sh_en = bus.en_in;
                    m_pend = 1'b1;
                end
                e.pend = m_pend;
                exp_q.push_back(e);
                if (m_cyc == D - 1) begin
                    m_cyc = 0;
                    m_idx = (m_idx == 0) ? N - 1 : m_idx - 1;
                end else begin
                    m_cyc++;
                end
                #1;
                if (!rst_de && exp_q.size() != 0) begin
                    got = {bus.an, bus.seg, bus.dp, bus.frame_done, bus.pending};
                    check("scoreboard", 32'(got), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Frame observation accumulators.
    int         an_low [N];
    int         dp_low [N];
    logic [6:0] seg_at [N];
    int         multi, blank_bad, pend_hi;

    task automatic clear_obs();
        for (int k = 0; k < N; k++) begin
            an_low[k] = 0; dp_low[k] = 0; seg_at[k] = 7'h7F;
        end
        multi = 0; blank_bad = 0; pend_hi = 0;
    endtask

    task automatic observe(input int n);
        repeat (n) begin
            @(negedge CLKDV);
            if (bus.pending) pend_hi++;
            if (bus.an == 4'hF) begin
                if (bus.seg !== 7'h7F || bus.dp !== 1'b1) blank_bad++;
            end else begin
                if ($countones(~bus.an) != 1) multi++;
                for (int k = 0; k < N; k++) begin
                    if (!bus.an[k]) begin
                        an_low[k]++;
                        seg_at[k] = bus.seg;
                        if (!bus.dp) dp_low[k]++;
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic [15:0] dig, input logic [3:0] dpv, input logic [3:0] env);
        bus.digits_in = dig;
        bus.dp_in     = dpv;
        bus.en_in     = env;
    endtask

    task automatic wait_fd();
        int t = 0;
        do begin
            @(negedge CLKDV);
            t++;
        end while (!bus.frame_done && t < 3 * FRAME);
        check("frame_done_seen", 32'(bus.frame_done), 32'd1);
    endtask

    task automatic wait_boundary();
        int t = 0;
        @(negedge CLKDV);
        while (!(m_cyc == D - 1 && m_idx == 0) && t < 3 * FRAME) begin
            @(negedge CLKDV);
            t++;
        end
        check("boundary_reached", 32'(m_cyc == D - 1 && m_idx == 0), 32'd1);
    endtask

    task automatic load_boundary(input logic [15:0] dig, input logic [3:0] dpv, input logic [3:0] env);
        wait_boundary();
        drive(dig, dpv, env);
        bus.load = 1'b1;
        @(negedge CLKDV);
        bus.load = 1'b0;
        check("boundary_load_no_pending", 32'(bus.pending), 32'd0);
        check("boundary_load_frame_done", 32'(bus.frame_done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},   32'(bus.an),         32'hF);
        check({tag, "_seg"},  32'(bus.seg),        32'h7F);
        check({tag, "_dp"},   32'(bus.dp),         32'd1);
        check({tag, "_fd"},   32'(bus.frame_done), 32'd0);
        check({tag, "_pend"}, 32'(bus.pending),    32'd0);
    endtask

    typedef struct {
        logic [3:0] val;
        logic       dp;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;

        vecs[0]  = '{4'h0, 1'b0, 7'h01}; vecs[1]  = '{4'h1, 1'b1, 7'h4F};
        vecs[2]  = '{4'h2, 1'b0, 7'h12}; vecs[3]  = '{4'h3, 1'b1, 7'h06};
        vecs[4]  = '{4'h4, 1'b0, 7'h4C}; vecs[5]  = '{4'h5, 1'b1, 7'h24};
        vecs[6]  = '{4'h6, 1'b0, 7'h20}; vecs[7]  = '{4'h7, 1'b1, 7'h0F};
        vecs[8]  = '{4'h8, 1'b0, 7'h00}; vecs[9]  = '{4'h9, 1'b1, 7'h04};
        vecs[10] = '{4'hA, 1'b0, 7'h08}; vecs[11] = '{4'hB, 1'b1, 7'h60};
        vecs[12] = '{4'hC, 1'b0, 7'h31}; vecs[13] = '{4'hD, 1'b1, 7'h42};
        vecs[14] = '{4'hE, 1'b0, 7'h30}; vecs[15] = '{4'hF, 1'b1, 7'h38};

        drive(16'h0000, 4'h0, 4'hF);
        bus.load      = 1'b0;
        bus.lamp_test = 1'b0;

        // Reset state, applied asynchronously before any clock edge.
        #2 rst_de = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge CLKDV);
        rst_de = 1'b0;

        // First slot: blank for B cycles, then digit 3 lit showing 0.
        @(negedge CLKDV); check("first_blank0", 32'(bus.an), 32'hF);
        @(negedge CLKDV); check("first_blank1", 32'(bus.an), 32'hF);
        @(negedge CLKDV); check("first_lit_an", 32'(bus.an), 32'b0111);
        check("first_lit_seg", 32'(bus.seg), 32'h01);

        // Frame period.
        wait_fd();
        t = 0;
        do begin
            @(negedge CLKDV);
            t++;
        end while (!bus.frame_done && t < 3 * FRAME);
        check("frame_period", 32'(t), 32'(FRAME));

        // Free-running frame of zeros.
        clear_obs();
        observe(FRAME);
        for (int k = 0; k < N; k++) begin
            check($sformatf("free_an%0d_low", k), 32'(an_low[k]), 32'(LIT));
            check($sformatf("free_seg%0d", k), 32'(seg_at[k]), 32'h01);
        end
        check("free_single_anode", 32'(multi), 32'd0);
        check("free_blank_outputs", 32'(blank_bad), 32'd0);
        check("free_dp_dark", 32'(dp_low[0] + dp_low[1] + dp_low[2] + dp_low[3]), 32'd0);

        // Mid-frame load: current frame unchanged, next frame shows it.
        clear_obs();
        drive(16'h1A3F, 4'b0100, 4'hF);
        bus.load = 1'b1;
        observe(1);
        bus.load = 1'b0;
        check("midload_pending", 32'(bus.pending), 32'd1);
        observe(FRAME - 1);
        for (int k = 0; k < N; k++)
            check($sformatf("midload_old_seg%0d", k), 32'(seg_at[k]), 32'h01);
        check("midload_commit_fd", 32'(bus.frame_done), 32'd1);
        check("midload_commit_pending", 32'(bus.pending), 32'd0);
        clear_obs();
        observe(FRAME);
        check("midload_seg3", 32'(seg_at[3]), 32'h4F);
        check("midload_seg2", 32'(seg_at[2]), 32'h08);
        check("midload_seg1", 32'(seg_at[1]), 32'h06);
        check("midload_seg0", 32'(seg_at[0]), 32'h38);
        check("midload_dp2", 32'(dp_low[2]), 32'(LIT));
        check("midload_dp_others", 32'(dp_low[3] + dp_low[1] + dp_low[0]), 32'd0);

        // Decode table, each loaded exactly on the boundary cycle (bypass path).
        for (int i = 0; i < 16; i++) begin
            load_boundary({4{vecs[i].val}}, {4{vecs[i].dp}}, 4'hF);
            clear_obs();
            observe(FRAME);
            check($sformatf("vec%0d_seg3", i), 32'(seg_at[3]), 32'(vecs[i].seg));
            check($sformatf("vec%0d_seg0", i), 32'(seg_at[0]), 32'(vecs[i].seg));
            check($sformatf("vec%0d_dp1", i), 32'(dp_low[1]), vecs[i].dp ? 32'(LIT) : 32'd0);
            check($sformatf("vec%0d_no_pending", i), 32'(pend_hi), 32'd0);
        end

        // Digit enables: an[2] and an[0] stay dark.
        load_boundary(16'h5678, 4'h0, 4'b1010);
        clear_obs();
        observe(FRAME);
        check("en_an2_dark", 32'(an_low[2]), 32'd0);
        check("en_an0_dark", 32'(an_low[0]), 32'd0);
        check("en_an3_lit", 32'(an_low[3]), 32'(LIT));
        check("en_seg3", 32'(seg_at[3]), 32'h24);
        check("en_seg1", 32'(seg_at[1]), 32'h0F);
        check("en_blank_outputs", 32'(blank_bad), 32'd0);

        // Lamp test lights enabled digits only, and releases on the next cycle.
        bus.lamp_test = 1'b1;
        clear_obs();
        observe(FRAME);
        check("lamp_seg3", 32'(seg_at[3]), 32'h00);
        check("lamp_seg1", 32'(seg_at[1]), 32'h00);
        check("lamp_dp3", 32'(dp_low[3]), 32'(LIT));
        check("lamp_dp1", 32'(dp_low[1]), 32'(LIT));
        check("lamp_an2_dark", 32'(an_low[2]), 32'd0);
        check("lamp_blank_outputs", 32'(blank_bad), 32'd0);
        observe(5);
        check("lamp_on_seg", 32'(bus.seg), 32'h00);
        bus.lamp_test = 1'b0;
        @(negedge CLKDV);
        check("lamp_off_seg", 32'(bus.seg), 32'h24);
        check("lamp_off_dp", 32'(bus.dp), 32'd1);

        // Two loads in one frame, then reset mid-frame discards them.
        wait_fd();
        drive(16'h9999, 4'hF, 4'hF);
        bus.load = 1'b1;
        @(negedge CLKDV);
        bus.load = 1'b0;
        repeat (5) @(negedge CLKDV);
        drive(16'h8888, 4'hF, 4'hF);
        bus.load = 1'b1;
        @(negedge CLKDV);
        bus.load = 1'b0;
        check("twoload_pending", 32'(bus.pending), 32'd1);
        repeat (3) @(negedge CLKDV);
        #2 rst_de = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge CLKDV);
        rst_de = 1'b0;
        wait_fd();
        clear_obs();
        observe(FRAME);
        for (int k = 0; k < N; k++) begin
            check($sformatf("postreset_seg%0d", k), 32'(seg_at[k]), 32'h01);
            check($sformatf("postreset_an%0d_low", k), 32'(an_low[k]), 32'(LIT));
        end
        check("postreset_no_pending", 32'(pend_hi), 32'd0);
        check("postreset_dp_dark", 32'(dp_low[0] + dp_low[1] + dp_low[2] + dp_low[3]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
